// File: rtl/ah_div_result_buffer_4.sv
// Four-entry result FIFO behind the 4/8 pipelined divider.
// Captures {err, quotient}, flags dropped results and counts divide-by-zero results.
module ah_div_result_buffer_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_quotient,
  input  logic       in_div_by_zero,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [3:0] out_quotient,
  output logic       out_err,
  output logic       ovf,
  output logic [7:0] dz_count,
  output logic [2:0] level
);

  logic [4:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [4:0] wdata;

  always_comb begin
    full  = (count == 3'd4);
    pop   = (count != 3'd0) && out_ready;
    // A full FIFO still accepts a result when the head leaves on the same edge.
    push  = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;
    wdata = in_div_by_zero ? 5'b1_0111 : {1'b0, in_quotient};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      dz_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (push && in_div_by_zero && (dz_count != 8'hFF)) dz_count <= dz_count + 8'd1;
    end
  end

  always_comb begin
    out_valid    = (count != 3'd0);
    out_quotient = mem[rd_ptr][3:0];
    out_err      = mem[rd_ptr][4];
    level        = count;
  end

endmodule

// File: tb/tb_ah_div_result_buffer_4.sv
// Bench for ah_div_result_buffer_4: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ah_div_result_buffer_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_quotient;
  logic       in_div_by_zero;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [3:0] out_quotient;
  logic       out_err;
  logic       ovf;
  logic [7:0] dz_count;
  logic [2:0] level;

  ah_div_result_buffer_4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_quotient(in_quotient),
    .in_div_by_zero(in_div_by_zero), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_quotient(out_quotient), .out_err(out_err),
    .ovf(ovf), .dz_count(dz_count), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of {err, quotient}
  logic [4:0] mq[$];
  logic       m_ovf;
  int unsigned m_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dz  = 0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (in_valid) begin
        if (mq.size() < 4) begin
          mq.push_back(in_div_by_zero ? 5'b1_0111 : {1'b0, in_quotient});
          if (in_div_by_zero && m_dz < 255) m_dz++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("level", {5'b0, level}, 8'(mq.size()));
      check("out_valid", {7'b0, out_valid}, {7'b0, mq.size() != 0});
      check("ovf", {7'b0, ovf}, {7'b0, m_ovf});
      check("dz_count", dz_count, 8'(m_dz));
      if (mq.size() != 0) begin
        check("out_quotient", {4'b0, out_quotient}, {4'b0, mq[0][3:0]});
        check("out_err", {7'b0, out_err}, {7'b0, mq[0][4]});
      end
    end
  end

  // Apply inputs for one cycle, return #1 after the rising edge.
  task automatic cyc(input logic v, input logic [3:0] q, input logic dz,
                     input logic rdy, input logic clr);
    in_valid = v; in_quotient = q; in_div_by_zero = dz; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_quotient = '0; in_div_by_zero = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check("rst_level", {5'b0, level}, 8'd0);
    check("rst_valid", {7'b0, out_valid}, 8'd0);
    check("rst_q", {4'b0, out_quotient}, 8'd0);
    check("rst_dz", dz_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single result, accepted on first edge after reset release
    cyc(1, 4'b1101, 0, 0, 0);
    check("s_valid", {7'b0, out_valid}, 8'd1);
    check("s_q", {4'b0, out_quotient}, 8'h0D);
    check("s_err", {7'b0, out_err}, 8'd0);
    check("s_level", {5'b0, level}, 8'd1);
    cyc(0, 0, 0, 1, 0);
    check("s_empty", {7'b0, out_valid}, 8'd0);

    // Divide by zero saturates quotient
    cyc(1, 4'b0000, 1, 0, 0);
    check("dz_q", {4'b0, out_quotient}, 8'h07);
    check("dz_err", {7'b0, out_err}, 8'd1);
    check("dz_cnt", dz_count, 8'd1);
    cyc(0, 0, 0, 1, 0);

    // Overflow: fifth push dropped
    for (int i = 1; i <= 5; i++) cyc(1, 4'(i), 0, 0, 0);
    check("ov_level", {5'b0, level}, 8'd4);
    check("ov_flag", {7'b0, ovf}, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      check("ov_drain", {4'b0, out_quotient}, 8'(i));
      cyc(0, 0, 0, 1, 0);
    end
    check("ov_empty", {7'b0, out_valid}, 8'd0);

    // Clear versus drop
    for (int i = 10; i <= 13; i++) cyc(1, 4'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("clr_only", {7'b0, ovf}, 8'd0);
    cyc(1, 4'd7, 0, 0, 1);
    check("clr_drop", {7'b0, ovf}, 8'd1);
    check("clr_level", {5'b0, level}, 8'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
    cyc(1, 4'd9, 0, 1, 0);
    check("pp_level", {5'b0, level}, 8'd4);
    check("pp_ovf", {7'b0, ovf}, 8'd0);
    begin
      logic [3:0] exp_seq [4];
      exp_seq[0] = 4'd2; exp_seq[1] = 4'd3; exp_seq[2] = 4'd4; exp_seq[3] = 4'd9;
      for (int i = 0; i < 4; i++) begin
        check("pp_drain", {4'b0, out_quotient}, {4'b0, exp_seq[i]});
        cyc(0, 0, 0, 1, 0);
      end
    end

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) cyc(1, 4'(i + 4), 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", {7'b0, out_valid}, 8'd0);
    check("mr_q", {4'b0, out_quotient}, 8'd0);
    check("mr_err", {7'b0, out_err}, 8'd0);
    check("mr_level", {5'b0, level}, 8'd0);
    check("mr_dz", dz_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 0);
    check("mr_after", {5'b0, level}, 8'd0);
    check("mr_after_v", {7'b0, out_valid}, 8'd0);

    // dz_count saturation
    for (int i = 0; i < 260; i++) cyc(1, 4'(i), 1, 1, 0);
    check("dz_sat", dz_count, 8'd255);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) < 60), 4'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 19) == 0));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ah_div_result_buffer_4.md
AH_DIV_RESULT_BUFFER_4 -- requirements
Module: ah_div_result_buffer_4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  divider result strobe, driven by the 4/8 pipelined divider's data_valid; no backpressure path exists.
REQ-005 in_quotient  input  4  signed two's-complement quotient from the divider.
REQ-006 in_div_by_zero  input  1  divider div_by_zero flag, aligned with in_valid.
REQ-007 out_ready  input  1  consumer accepts the head entry.
REQ-008 clr_ovf  input  1  synchronous clear of the ovf sticky flag.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_quotient  output  4  head entry quotient.
REQ-011 out_err  output  1  head entry was a divide-by-zero.
REQ-012 ovf  output  1  sticky flag, set when a result was dropped.
REQ-013 dz_count  output  8  saturating count of divide-by-zero results accepted.
REQ-014 level  output  3  current occupancy, 0..4.

Function
REQ-015 Storage SHALL be a 4-entry FIFO of 5-bit entries {err, quotient}.
- Implementation: 2-bit read/write pointers plus a 3-bit count.
REQ-016 Push SHALL occur on a clock edge where in_valid=1 and the FIFO is not full, or where it is full and a pop occurs on the same edge.
REQ-017 Pop SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-018 Push data SHALL be {1, 4'b0111} when in_div_by_zero=1.
- Saturated quotient replaces the raw value.
- Otherwise push data SHALL be {0, in_quotient}.
REQ-019 Latency: a push on edge N SHALL make the entry visible at the outputs after edge N.
- No same-cycle pass-through, including when empty.
REQ-020 out_valid SHALL equal (level != 0).
REQ-021 out_quotient and out_err SHALL reflect the entry at the read pointer.
- Held stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-023 Pointers SHALL wrap 3 -> 0.
REQ-024 Full with in_valid=1 and no pop: the result SHALL be discarded.
- FIFO contents SHALL remain unchanged.
- ovf SHALL be set on that edge.
REQ-025 ovf SHALL stay at 1 until clr_ovf=1.
- If clr_ovf=1 and a drop occur on the same edge, ovf SHALL end up 1 (set wins).
REQ-026 dz_count SHALL increment only on pushed entries with err=1, never on dropped ones.
- Saturates at 255, no wrap.
REQ-027 out_ready while empty SHALL have no effect.
REQ-028 in_valid=0 SHALL ignore in_quotient and in_div_by_zero.

Reset
REQ-029 rst_n=0 SHALL immediately clear, independent of clk:
- out_valid=0, out_quotient=0, out_err=0
- ovf=0, dz_count=0, level=0
- both pointers to 0
REQ-030 Reset asserted mid-operation SHALL discard all stored entries.
- No stale entry SHALL appear after release.
REQ-031 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Single result: push quotient 4'b1101 with out_ready=0 -> next cycle out_valid=1, out_quotient=4'b1101, out_err=0, level=1; then out_ready=1 -> out_valid=0 next cycle.
REQ-033 Divide-by-zero: push in_div_by_zero=1, in_quotient=4'b0000 -> out_quotient=4'b0111, out_err=1, dz_count=1.
REQ-034 Overflow: 5 consecutive pushes 1,2,3,4,5 with out_ready=0 -> level=4, ovf=1; then drain with out_ready=1 -> outputs 1,2,3,4; 5 never appears.
REQ-035 Full with simultaneous push and pop: preload 1..4, then push 9 with out_ready=1 -> pops 1, level stays 4, ovf stays 0; drain yields 2,3,4,9.
REQ-036 Clear versus drop: ovf=1, FIFO full; pulse clr_ovf with no push -> ovf=0; pulse clr_ovf together with a dropped push -> ovf=1.
REQ-037 Reset mid-stream: preload 3 entries, assert rst_n=0 between edges -> outputs zero immediately; after release, level=0 and out_valid=0 until the next push.
